m_pte_port: RTL

Memory-side responder for page-table-walker PTE traffic. Accepts single-word PTE read and PTE write-back requests from the MMU walker and converts them into transactions on a generic DRAM request/grant/read-valid port. Holds a one-entry PTE buffer so repeated L1 reads of the same PTE skip DRAM, and converts a hung DRAM transaction into an error completion with an invalid PTE (all zeros), so the walker faults instead of hanging.

---
 rtl/m_pte_port_pkg.sv | 20 ++
 rtl/m_pte_buf.sv | 48 ++++
 rtl/m_pte_port.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/m_pte_port_pkg.sv
// Shared types and constants for the page-table-walker PTE memory port.
// The V-bit mask is common with the MMU walker's PTE decode.
package m_pte_port_pkg;

  typedef enum logic [1:0] {
    PTP_IDLE   = 2'd0,
    PTP_REQ    = 2'd1,
    PTP_RDWAIT = 2'd2
  } ptp_state_e;

  localparam int          PTE_TAG_W    = 30;
  localparam logic [31:0] PTE_V_MASK   = 32'h0000_0001;
  localparam logic [31:0] PTE_OFS_MASK = 32'h0000_0003;

  // PTEs are word aligned; the low address bits carry no information.
  function automatic logic [31:0] pte_align(input logic [31:0] addr);
    return addr & ~PTE_OFS_MASK;
  endfunction

endpackage

// File: rtl/m_pte_buf.sv
// One-entry PTE buffer: tag/data/valid with combinational lookup,
// fill on read completion, data update on write-back, and flush.
module m_pte_buf
  import m_pte_port_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [PTE_TAG_W-1:0] lookup_tag,
  output logic                 lookup_hit,
  output logic [31:0]          lookup_data,
  input  logic                 fill_en,
  input  logic [PTE_TAG_W-1:0] fill_tag,
  input  logic [31:0]          fill_data,
  input  logic                 upd_en,
  input  logic [PTE_TAG_W-1:0] upd_tag,
  input  logic [31:0]          upd_data,
  input  logic                 flush
);

  logic                 valid_reg;
  logic [PTE_TAG_W-1:0] tag_reg;
  logic [31:0]          data_reg;

  // Flush beats a same-cycle fill so a stale PTE never survives sfence.vma.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (fill_en) begin
        valid_reg <= 1'b1;
      end
      if (fill_en && !flush) begin
        tag_reg  <= fill_tag;
        data_reg <= fill_data;
      end else if (upd_en && valid_reg && (tag_reg == upd_tag)) begin
        data_reg <= upd_data;
      end
    end
  end

  assign lookup_hit  = valid_reg && (tag_reg == lookup_tag);
  assign lookup_data = data_reg;

endmodule

// File: rtl/m_pte_port.sv
// PTE read/write-back responder for the MMU walker: single-entry PTE buffer
// in front of a DRAM req/gnt/rvalid port, with a timeout that forces an error.
module m_pte_port
  import m_pte_port_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter bit BUF_EN  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_dram_req,
  output logic        o_dram_we,
  output logic [31:0] o_dram_addr,
  output logic [31:0] o_dram_wdata,
  input  logic        i_dram_gnt,
  input  logic        i_dram_rvalid,
  input  logic [31:0] i_dram_rdata
);

  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  ptp_state_e    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          we_reg, we_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          timeout_hit;
  logic          buf_hit;
  logic [31:0]   buf_data;
  logic          fill_en;
  logic          upd_en;

  generate
    if (BUF_EN) begin : g_buf
      m_pte_buf u_buf (
        .CLK         (CLK),
        .RST         (RST),
        .lookup_tag  (i_addr[31:2]),
        .lookup_hit  (buf_hit),
        .lookup_data (buf_data),
        .fill_en     (fill_en),
        .fill_tag    (addr_reg[31:2]),
        .fill_data   (i_dram_rdata),
        .upd_en      (upd_en),
        .upd_tag     (addr_reg[31:2]),
        .upd_data    (wdata_reg),
        .flush       (i_flush)
      );
    end else begin : g_nobuf
      assign buf_hit  = 1'b0;
      assign buf_data = '0;
    end
  endgenerate

  assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    fill_en    = 1'b0;
    upd_en     = 1'b0;
    case (state_reg)
      PTP_IDLE: begin
        if (i_req) begin
          if (!i_we && buf_hit && !i_flush) begin
            rdata_next = buf_data;
            done_next  = 1'b1;
          end else begin
            we_next    = i_we;
            addr_next  = pte_align(i_addr);
            wdata_next = i_wdata;
            cnt_next   = '0;
            state_next = PTP_REQ;
          end
        end
      end
      PTP_REQ: begin
        // A real completion takes precedence over a timeout in the same cycle.
        if (i_dram_gnt && we_reg) begin
          done_next  = 1'b1;
          upd_en     = 1'b1;
          state_next = PTP_IDLE;
        end else if (i_dram_gnt && i_dram_rvalid) begin
          rdata_next = i_dram_rdata;
          done_next  = 1'b1;
          fill_en    = 1'b1;
          state_next = PTP_IDLE;
        end else if (timeout_hit) begin
          rdata_next = '0;
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = PTP_IDLE;
        end else begin
          cnt_next = cnt_inc;
          if (i_dram_gnt) begin
            state_next = PTP_RDWAIT;
          end
        end
      end
      PTP_RDWAIT: begin
        if (i_dram_rvalid) begin
          rdata_next = i_dram_rdata;
          done_next  = 1'b1;
          fill_en    = 1'b1;
          state_next = PTP_IDLE;
        end else if (timeout_hit) begin
          rdata_next = '0;
          done_next  = 1'b1;
          err_next   = 1'b1;
          state_next = PTP_IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: state_next = PTP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= PTP_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign o_busy       = (state_reg != PTP_IDLE);
  assign o_done       = done_reg;
  assign o_err        = err_reg;
  assign o_rdata      = rdata_reg;
  assign o_dram_req   = (state_reg == PTP_REQ);
  assign o_dram_we    = we_reg;
  assign o_dram_addr  = addr_reg;
  assign o_dram_wdata = wdata_reg;

endmodule
